// File: rtl/heichips25_pkg.sv
// Shared types and widths for the HeiChips25 pad-side request/response path.
package heichips25_pkg;

  localparam int unsigned NibbleWidth = 4;
  localparam int unsigned DataWidth   = 32;

  typedef enum logic {
    RSP_DATA = 1'b0,
    RSP_INST = 1'b1
  } rsp_tag_e;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/nibble_rsp_deser_if.sv
// Pin-side beat handshake plus core-side response handshake of the deserializer.
interface nibble_rsp_deser_if #(
  parameter int unsigned DataWidth   = heichips25_pkg::DataWidth,
  parameter int unsigned NibbleWidth = heichips25_pkg::NibbleWidth
);
  import heichips25_pkg::*;

  // Both sides use valid/ready: a transfer happens on the rising clock edge
  // where valid and ready are both high; the source holds its payload and
  // valid until then, and valid never drops without a transfer.
  logic [NibbleWidth-1:0] nib;
  logic                   nib_valid;
  logic                   nib_ready;
  logic                   tag;
  logic                   flush;
  logic [DataWidth-1:0]   rsp_data;
  rsp_tag_e               rsp_tag;
  logic                   rsp_valid;
  logic                   rsp_ready;
  hold_state_e            hold_state;

  modport master (
    output nib, nib_valid, tag, flush, rsp_ready,
    input  nib_ready, rsp_data, rsp_tag, rsp_valid, hold_state
  );

  modport slave (
    input  nib, nib_valid, tag, flush, rsp_ready,
    output nib_ready, rsp_data, rsp_tag, rsp_valid, hold_state
  );

endinterface

// File: rtl/nibble_rsp_deser.sv
// Collects Beats LSB-first nibbles into one word and holds it in a one-entry
// spill stage until the core pops it.
module nibble_rsp_deser #(
  parameter int unsigned DataWidth   = heichips25_pkg::DataWidth,
  parameter int unsigned NibbleWidth = heichips25_pkg::NibbleWidth
) (
  input logic               clk_i,
  input logic               rst_i,
  nibble_rsp_deser_if.slave bus
);
  import heichips25_pkg::*;

  localparam int unsigned Beats = DataWidth / NibbleWidth;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  logic [CntW-1:0]      cnt_q;
  logic [DataWidth-1:0] shift_q;
  logic [DataWidth-1:0] shift_d;
  rsp_tag_e             tag_q;
  rsp_tag_e             word_tag;
  hold_state_e          state_q, state_d;
  logic [DataWidth-1:0] data_q;
  rsp_tag_e             rsp_tag_q;
  logic                 load_en;
  logic                 last_beat;
  logic                 beat_fire;
  logic                 word_done;

  assign last_beat = (cnt_q == LastCnt);
  // Only the final beat can stall: it needs a free (or freeing) holding slot.
  assign bus.nib_ready = !bus.flush &&
                         (!last_beat || state_q == HOLD_EMPTY || bus.rsp_ready);
  assign beat_fire = bus.nib_valid && bus.nib_ready;
  assign word_done = beat_fire && last_beat;

  if (Beats > 1) begin : g_shift
    assign shift_d = {bus.nib, shift_q[DataWidth-1:NibbleWidth]};
  end else begin : g_single
    assign shift_d = bus.nib;
  end

  // First beat of a word carries its tag; with one beat per word it is live.
  assign word_tag = (cnt_q == '0) ? rsp_tag_e'(bus.tag) : tag_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush) begin
      cnt_q   <= '0;
      shift_q <= '0;
      tag_q   <= RSP_DATA;
    end else if (beat_fire) begin
      shift_q <= shift_d;
      if (cnt_q == '0) tag_q <= rsp_tag_e'(bus.tag);
      cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= HOLD_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    case (state_q)
      HOLD_EMPTY: begin
        if (word_done) begin
          state_d = HOLD_FULL;
          load_en = 1'b1;
        end
      end
      HOLD_FULL: begin
        // A last beat here implies a pop this cycle; the new word replaces it.
        if (word_done) begin
          load_en = 1'b1;
        end else if (bus.rsp_ready) begin
          state_d = HOLD_EMPTY;
        end
      end
      default: state_d = HOLD_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q    <= '0;
      rsp_tag_q <= RSP_DATA;
    end else if (load_en) begin
      data_q    <= shift_d;
      rsp_tag_q <= word_tag;
    end
  end

  assign bus.rsp_data   = data_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_valid  = (state_q == HOLD_FULL);
  assign bus.hold_state = state_q;

endmodule

// File: tb/tb_nibble_rsp_deser.sv
// Directed bench for nibble_rsp_deser with a pop-side scoreboard.
module tb_nibble_rsp_deser;
  import heichips25_pkg::*;

  localparam int unsigned DW = heichips25_pkg::DataWidth;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_pops;
  logic [DW:0] exp_q[$];
  logic        held;
  logic [DW:0] held_word;

  nibble_rsp_deser_if bus ();

  nibble_rsp_deser dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // driver tasks: entered and left at posedge+1
  task automatic send_beat(input logic [3:0] n, input logic t, output int cycles);
    logic acc;
    acc = 1'b0;
    cycles = 0;
    bus.nib = n;
    bus.tag = t;
    bus.nib_valid = 1'b1;
    while (!acc && cycles < 50) begin
      @(negedge clk);
      acc = bus.nib_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    bus.nib_valid = 1'b0;
    check("beat_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic t, input int max_gap);
    int c;
    for (int i = 0; i < 8; i++) begin
      send_beat(w[i*4 +: 4], (i == 0) ? t : 1'b0, c);
      if (max_gap > 0 && i < 7) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard: compares every popped word and watches stability under stall
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && bus.rsp_valid)
        check("hold_stable", 64'({bus.rsp_tag, bus.rsp_data}), 64'(held_word));
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_pops++;
        if (exp_q.size() == 0) check("word_expected", 64'(exp_q.size()), 64'd1);
        else check("rsp_word", 64'({bus.rsp_tag, bus.rsp_data}), 64'(exp_q.pop_front()));
      end
      held = bus.rsp_valid && !bus.rsp_ready;
      held_word = {bus.rsp_tag, bus.rsp_data};
    end
  end

  initial begin
    int c;
    int total;
    int pops0;
    n_checks = 0;
    n_fail = 0;
    n_pops = 0;
    held = 1'b0;
    held_word = '0;
    bus.nib = 4'hF;
    bus.nib_valid = 1'b1;
    bus.tag = 1'b0;
    bus.flush = 1'b0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;

    // reset with a beat offered
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_data", 64'(bus.rsp_data), 64'd0);
    end
    rst = 1'b0;
    bus.nib_valid = 1'b0;
    #1;
    check("rst_nib_ready", 64'(bus.nib_ready), 64'd1);
    check("rst_state", 64'(bus.hold_state), 64'(HOLD_EMPTY));
    idle(1);

    // back-to-back beats 1..8, instruction tag
    exp_q.push_back({1'b1, 32'h8765_4321});
    total = 0;
    for (int i = 0; i < 8; i++) begin
      send_beat(4'(i + 1), (i == 0), c);
      total += c;
      if (i == 6) check("b2b_valid_early", 64'(bus.rsp_valid), 64'd0);
    end
    check("b2b_cycles", 64'(total), 64'd8);
    check("b2b_valid", 64'(bus.rsp_valid), 64'd1);
    check("b2b_data", 64'(bus.rsp_data), 64'h8765_4321);
    check("b2b_tag", 64'(bus.rsp_tag), 64'd1);
    idle(1);
    check("b2b_valid_once", 64'(bus.rsp_valid), 64'd0);

    // same word with random idle gaps
    pops0 = n_pops;
    exp_q.push_back({1'b1, 32'h8765_4321});
    send_word(32'h8765_4321, 1'b1, 3);
    idle(3);
    check("gap_pops", 64'(n_pops - pops0), 64'd1);

    // backpressure: second word's last beat waits for the pop
    bus.rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'hAAAA_AAAA});
    exp_q.push_back({1'b0, 32'h5555_5555});
    send_word(32'hAAAA_AAAA, 1'b0, 0);
    for (int i = 0; i < 7; i++) send_beat(4'h5, 1'b0, c);
    bus.nib = 4'h5;
    bus.nib_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_nib_ready", 64'(bus.nib_ready), 64'd0);
      check("bp_data", 64'(bus.rsp_data), 64'hAAAA_AAAA);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(bus.nib_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.nib_valid = 1'b0;
    check("bp_swap_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp_swap_data", 64'(bus.rsp_data), 64'h5555_5555);
    idle(2);
    check("bp_drained", 64'(bus.rsp_valid), 64'd0);

    // flush drops a partial word and a concurrent beat
    pops0 = n_pops;
    for (int i = 0; i < 3; i++) send_beat(4'hF, 1'b1, c);
    bus.flush = 1'b1;
    bus.nib = 4'hF;
    bus.nib_valid = 1'b1;
    @(negedge clk);
    check("flush_nib_ready", 64'(bus.nib_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.nib_valid = 1'b0;
    exp_q.push_back({1'b0, 32'hCCCC_CCCC});
    send_word(32'hCCCC_CCCC, 1'b0, 0);
    idle(2);
    check("flush_pops", 64'(n_pops - pops0), 64'd1);

    // reset mid-word
    pops0 = n_pops;
    for (int i = 0; i < 5; i++) send_beat(4'h7, 1'b0, c);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_q.push_back({1'b0, 32'h3333_3333});
    send_word(32'h3333_3333, 1'b0, 0);
    idle(2);
    check("rstmid_pops", 64'(n_pops - pops0), 64'd1);

    // reset drops a held word
    bus.rsp_ready = 1'b0;
    send_word(32'h9999_9999, 1'b1, 0);
    check("held_valid", 64'(bus.rsp_valid), 64'd1);
    check("held_data", 64'(bus.rsp_data), 64'h9999_9999);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("held_drop_valid", 64'(bus.rsp_valid), 64'd0);
    check("held_drop_data", 64'(bus.rsp_data), 64'd0);
    bus.rsp_ready = 1'b1;
    idle(3);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
